pipe_stage_reg: RTL and testbench

Parametrised pipeline transfer register with a ready/valid handshake, flush-to-bubble and a saturating stall counter, used between any two stages of the RV32 pipeline (I→X, X→M, M→W). It carries a PC, a generic payload and an instruction word. On reset or flush, the held instruction becomes a NOP. An optional two-entry skid buffer breaks the combinational ready path, so stages can be retimed independently.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/sat_counter.sv | 28 ++
 rtl/pipe_stage_reg.sv | 166 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the RV32 pipeline transfer registers: stage-buffer
// state encoding, the canonical NOP and the per-stage payload widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_ONE   = 2'd1,
    PIPE_TWO   = 2'd2
  } pipe_state_e;

  // addi x0,x0,0 -- the bubble presented by an empty stage.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam int I2X_DATA_W = 96;  // rs1 data + rs2 data + immediate
  localparam int X2M_DATA_W = 64;  // ALU result + store data

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over enable.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = (r_count == {WIDTH{1'b1}});

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_at_max) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline transfer register with ready/valid handshake, flush-to-bubble and
// a saturating stall counter. Define PIPE_STAGE_SKID_EN for the two-entry skid buffer.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = I2X_DATA_W,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(pipe_pkg::NOP_INST),
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [INST_W-1:0] out_inst,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              w_accept;
  logic              w_consume;
  logic              w_stall;
  logic [31:0]       r_pc;
  logic [DATA_W-1:0] r_data;
  logic [INST_W-1:0] r_inst;

  assign w_accept  = in_valid && in_ready;
  assign w_consume = out_valid && out_ready;
  assign w_stall   = out_valid && !out_ready;

`ifdef PIPE_STAGE_SKID_EN

  pipe_state_e       r_state;
  pipe_state_e       w_next_state;
  logic              r_in_ready;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid;
  logic [31:0]       r_skid_pc;
  logic [DATA_W-1:0] r_skid_data;
  logic [INST_W-1:0] r_skid_inst;

  // r_in_ready tracks (state != TWO) one cycle early so in_ready never sees out_ready.
  assign in_ready  = r_in_ready && !reset;
  assign out_valid = (r_state != PIPE_EMPTY);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value held and infer a latch.
  always_comb begin
    w_next_state     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    unique case (r_state)
      PIPE_EMPTY: begin
        if (w_accept) begin
          w_next_state   = PIPE_ONE;
          w_load_main_in = 1'b1;
        end
      end
      PIPE_ONE: begin
        if (w_accept && !w_consume) begin
          w_next_state = PIPE_TWO;
          w_load_skid  = 1'b1;
        end else if (w_accept && w_consume) begin
          w_load_main_in = 1'b1;
        end else if (w_consume) begin
          w_next_state = PIPE_EMPTY;
        end
      end
      PIPE_TWO: begin
        if (w_consume) begin
          w_next_state     = PIPE_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_next_state = PIPE_EMPTY;
    endcase
    if (flush) begin
      w_next_state     = PIPE_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= PIPE_EMPTY;
      r_in_ready <= 1'b1;
      r_pc       <= '0;
      r_data     <= '0;
      r_inst     <= NOP_INST;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != PIPE_TWO);
      if (w_load_main_in) begin
        r_pc   <= in_pc;
        r_data <= in_data;
        r_inst <= in_inst;
      end else if (w_load_main_skid) begin
        r_pc   <= r_skid_pc;
        r_data <= r_skid_data;
        r_inst <= r_skid_inst;
      end
    end
  end

  // NOTE: the skid entry is plain storage with no reset; its validity lives
  // entirely in r_state, which is reset.
  always_ff @(posedge clk) begin
    if (w_load_skid) begin
      r_skid_pc   <= in_pc;
      r_skid_data <= in_data;
      r_skid_inst <= in_inst;
    end
  end

`else

  logic r_valid;

  assign in_ready  = !reset && (!r_valid || out_ready);
  assign out_valid = r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_data  <= '0;
      r_inst  <= NOP_INST;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_pc    <= in_pc;
      r_data  <= in_data;
      r_inst  <= in_inst;
    end else if (w_consume) begin
      r_valid <= 1'b0;
    end
  end

`endif

  assign out_pc   = r_pc;
  assign out_data = r_data;
  assign out_inst = out_valid ? r_inst : NOP_INST;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .i_clr   (reset),
    .i_en    (w_stall),
    .o_count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random
// traffic, compared against a FIFO-of-entries reference model.
module tb_pipe_stage_reg;

  localparam int          DATA_W = 96;
  localparam int          INST_W = 32;
  localparam int          CNT_W  = 4;
  localparam int          MAXC   = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int CAP = SKID ? 2 : 1;

  typedef struct {
    logic [31:0]       pc;
    logic [DATA_W-1:0] data;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]       in_pc, out_pc;
  logic [DATA_W-1:0] in_data, out_data;
  logic [INST_W-1:0] in_inst, out_inst;
  logic [CNT_W-1:0]  stall_cnt;

  entry_t            q[$];
  int                stall_m;
  logic [31:0]       last_pc;
  logic [DATA_W-1:0] last_data;
  logic              last_ready, last_acc;
  int                errors = 0;
  int                checks = 0;

  logic [31:0] stream_pcs [5];
  logic [11:0] ordy_pat;
  int          idx;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W   (DATA_W),
    .INST_W   (INST_W),
    .NOP_INST (NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_data   (in_data),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_data  (out_data),
    .out_inst  (out_inst),
    .stall_cnt (stall_cnt)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: compare outputs at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    logic              ev, er, acc, cons;
    logic [INST_W-1:0] ein;
    entry_t            cur;
    @(negedge clk);
    ev  = (q.size() != 0);
    er  = !reset && ((q.size() < CAP) || (!SKID && out_ready));
    ein = NOP;
    if (ev) ein = q[0].inst;
    check("in_ready", in_ready, er);
    check("out_valid", out_valid, ev);
    check("out_inst", out_inst, ein);
    check("out_pc", out_pc, last_pc);
    check("out_data", out_data, last_data);
    check("stall_cnt", stall_cnt, stall_m);
    acc        = in_valid && er;
    cons       = ev && out_ready;
    cur.pc     = in_pc;
    cur.data   = in_data;
    cur.inst   = in_inst;
    last_ready = er;
    last_acc   = acc;
    @(posedge clk);
    if (reset) begin
      q.delete();
      stall_m   = 0;
      last_pc   = '0;
      last_data = '0;
    end else begin
      if (ev && !out_ready && stall_m < MAXC) stall_m++;
      if (flush) begin
        q.delete();
      end else begin
        if (cons) void'(q.pop_front());
        if (acc) q.push_back(cur);
      end
    end
    if (q.size() != 0) begin
      last_pc   = q[0].pc;
      last_data = q[0].data;
    end
    #1;
  endtask

  task automatic offer(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_data  = {pc ^ 32'hA5A5_0000, ~pc, pc + 32'd1};
    in_inst  = {pc[11:0], 20'h00093};
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    stream_pcs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    ordy_pat   = 12'b1111_1110_0011;  // bit c = out_ready in cycle c
    q.delete();
    stall_m = 0; last_pc = '0; last_data = '0; last_ready = 1'b0; last_acc = 1'b0;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    offer(32'h100);

    // Reset held two cycles with a valid offer pending.
    @(posedge clk); #1;
    cycle();
    reset = 1'b0; in_valid = 1'b0;
    cycle();

    // Streaming, then three cycles of backpressure, then release.
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      if (idx < 5) offer(stream_pcs[idx]);
      else in_valid = 1'b0;
      out_ready = ordy_pat[c];
      cycle();
      if (last_acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();

    // Fill the stage under backpressure, then flush with a new offer.
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 3; c++) begin
      if (idx < 2) offer(32'h20 + 32'(idx * 4));
      else in_valid = 1'b0;
      cycle();
      if (last_acc) idx++;
    end
    offer(32'hC); out_ready = 1'b1; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    cycle();
    check("post_flush_valid", out_valid, 1'b0);
    check("post_flush_inst", out_inst, NOP);
    cycle();

    // Stall-counter saturation and clear by reset.
    offer(32'h40); out_ready = 1'b0;
    for (int c = 0; c < 20; c++) cycle();
    check("stall_sat", stall_cnt, 4'hF);
    reset = 1'b1; in_valid = 1'b0;
    cycle();
    reset = 1'b0;
    cycle();
    check("stall_after_reset", stall_cnt, 4'h0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 800; i++) begin
      if (!(in_valid && !last_ready)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_pc    = $urandom;
        in_data  = {$urandom, $urandom, $urandom};
        in_inst  = $urandom;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
